// File: rtl/ni_irq_pkg.sv
// Shared types for the NI receive-event path feeding the IRQ FIFO.
package ni_irq_pkg;

  localparam int IRQ_ADDR_W = 14;

  typedef enum logic {
    CLS_DATA = 1'b0,
    CLS_IRQ  = 1'b1
  } irq_class_t;

  typedef logic [IRQ_ADDR_W-1:0] irq_addr_t;

endpackage

// File: rtl/evt_queue.sv
// Small flip-flop FIFO holding pending events of one class; head is combinational.
module evt_queue #(
  parameter int W     = 14,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/irq_event_arb.sv
// Merges interrupt and data-completion events into the IRQ FIFO's single write port,
// round-robin between two holding queues, with sticky overflow flags.
module irq_event_arb
  import ni_irq_pkg::*;
#(
  parameter int ADDR_W = IRQ_ADDR_W,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_irq_valid,
  input  logic [ADDR_W-1:0] rx_irq_addr,
  input  logic              rx_data_valid,
  input  logic [ADDR_W-1:0] rx_data_addr,
  output logic              irq_irq_fifo_data_valid,
  output logic              irq_data_fifo_data_valid,
  output logic [ADDR_W-1:0] irq_data_fifo_data,
  output logic              ovf_irq,
  output logic              ovf_data,
  input  logic              ovf_clr
);

  // Handshake: every valid here is a one-cycle strobe with no ready; a strobe is
  // consumed at the rising edge it is sampled on, and the FIFO side never stalls.

  logic [ADDR_W-1:0] irq_head;
  logic [ADDR_W-1:0] data_head;
  logic              irq_empty;
  logic              irq_full;
  logic              data_empty;
  logic              data_full;
  logic              grant_irq;
  logic              grant_data;
  logic              irq_drop;
  logic              data_drop;
  irq_class_t        rr_last;

  evt_queue #(.W(ADDR_W), .DEPTH(QDEPTH)) u_irq_q (
    .clk   (clk),
    .reset (reset),
    .push  (rx_irq_valid),
    .din   (rx_irq_addr),
    .pop   (grant_irq),
    .dout  (irq_head),
    .empty (irq_empty),
    .full  (irq_full)
  );

  evt_queue #(.W(ADDR_W), .DEPTH(QDEPTH)) u_data_q (
    .clk   (clk),
    .reset (reset),
    .push  (rx_data_valid),
    .din   (rx_data_addr),
    .pop   (grant_data),
    .dout  (data_head),
    .empty (data_empty),
    .full  (data_full)
  );

  // Grants are mutually exclusive by construction, which keeps the two valids exclusive.
  always_comb begin
    grant_data = ~data_empty & (irq_empty | (rr_last == CLS_IRQ));
    grant_irq  = ~irq_empty & ~grant_data;
  end

  assign irq_drop  = rx_irq_valid  & irq_full  & ~grant_irq;
  assign data_drop = rx_data_valid & data_full & ~grant_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last                  <= CLS_IRQ;
      irq_irq_fifo_data_valid  <= 1'b0;
      irq_data_fifo_data_valid <= 1'b0;
      irq_data_fifo_data       <= '0;
      ovf_irq                  <= 1'b0;
      ovf_data                 <= 1'b0;
    end else begin
      irq_irq_fifo_data_valid  <= grant_irq;
      irq_data_fifo_data_valid <= grant_data;
      if (grant_data)     irq_data_fifo_data <= data_head;
      else if (grant_irq) irq_data_fifo_data <= irq_head;
      if (~irq_empty & ~data_empty) rr_last <= grant_irq ? CLS_IRQ : CLS_DATA;
      // A drop in the same cycle as a clear must leave the flag set.
      ovf_irq  <= irq_drop  | (ovf_irq  & ~ovf_clr);
      ovf_data <= data_drop | (ovf_data & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_irq_event_arb.sv
// Directed bench for irq_event_arb: queue model feeds an expected-beat scoreboard.
module tb_irq_event_arb;

  localparam int AW = 14;
  localparam int QD = 4;

  logic          clk;
  logic          reset;
  logic          rx_irq_valid;
  logic [AW-1:0] rx_irq_addr;
  logic          rx_data_valid;
  logic [AW-1:0] rx_data_addr;
  logic          vi;
  logic          vd;
  logic [AW-1:0] data;
  logic          ovf_irq;
  logic          ovf_data;
  logic          ovf_clr;

  int vectors;
  int miscompares;
  int cyc;

  logic [AW:0]   exp_q[$];
  int            exp_cyc_q[$];
  logic [AW-1:0] mi[$];
  logic [AW-1:0] md[$];
  logic          m_rr_irq;
  logic          m_ovf_irq;
  logic          m_ovf_data;
  logic          gd;
  logic          gi;
  logic          di;
  logic          dd;
  logic [AW:0]   e;
  int            ec;
  logic [AW-1:0] last_data;

  irq_event_arb #(.ADDR_W(AW), .QDEPTH(QD)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .rx_irq_valid             (rx_irq_valid),
    .rx_irq_addr              (rx_irq_addr),
    .rx_data_valid            (rx_data_valid),
    .rx_data_addr             (rx_data_addr),
    .irq_irq_fifo_data_valid  (vi),
    .irq_data_fifo_data_valid (vd),
    .irq_data_fifo_data       (data),
    .ovf_irq                  (ovf_irq),
    .ovf_data                 (ovf_data),
    .ovf_clr                  (ovf_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: per-class queues, round-robin flag, sticky flags.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      mi.delete();
      md.delete();
      m_rr_irq   = 1'b1;
      m_ovf_irq  = 1'b0;
      m_ovf_data = 1'b0;
    end else begin
      gd = (md.size() > 0) && ((mi.size() == 0) || m_rr_irq);
      gi = (mi.size() > 0) && !gd;
      if ((md.size() > 0) && (mi.size() > 0)) m_rr_irq = gi;
      if (gd) begin
        exp_q.push_back({1'b0, md.pop_front()});
        exp_cyc_q.push_back(cyc);
      end
      if (gi) begin
        exp_q.push_back({1'b1, mi.pop_front()});
        exp_cyc_q.push_back(cyc);
      end
      di = 1'b0;
      dd = 1'b0;
      if (rx_irq_valid) begin
        if (mi.size() < QD) mi.push_back(rx_irq_addr);
        else di = 1'b1;
      end
      if (rx_data_valid) begin
        if (md.size() < QD) md.push_back(rx_data_addr);
        else dd = 1'b1;
      end
      m_ovf_irq  = di | (m_ovf_irq & !ovf_clr);
      m_ovf_data = dd | (m_ovf_data & !ovf_clr);
    end
  end

  // Monitor: pops the expected queue on every output beat.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_valids", 32'({vi, vd}), 32'(0));
      last_data = '0;
    end else begin
      chk("valid_excl", 32'(vi & vd), 32'(0));
      if (vi | vd) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got vi=%0b vd=%0b data=0x%0h expected no beat (cycle %0d)",
                   vi, vd, data, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("beat_class", 32'(vi), 32'(e[AW]));
          chk("beat_addr", 32'(data), 32'(e[AW-1:0]));
          chk("beat_cycle", 32'(cyc), 32'(ec));
          last_data = e[AW-1:0];
        end
      end else begin
        if ((exp_q.size() > 0) && (exp_cyc_q[0] <= cyc)) begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL missing_beat: got no beat expected cls=%0b addr=0x%0h (cycle %0d)",
                   e[AW], e[AW-1:0], ec);
        end
        chk("data_hold", 32'(data), 32'(last_data));
      end
      chk("ovf_irq", 32'(ovf_irq), 32'(m_ovf_irq));
      chk("ovf_data", 32'(ovf_data), 32'(m_ovf_data));
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    cyc           = 0;
    last_data     = '0;
    reset         = 1'b0;
    rx_irq_valid  = 1'b0;
    rx_irq_addr   = '0;
    rx_data_valid = 1'b0;
    rx_data_addr  = '0;
    ovf_clr       = 1'b0;
    idle(3);
    reset = 1'b1;

    // 1: idle after reset
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t1_idle_flags", 32'({vi, vd, ovf_irq, ovf_data}), 32'(0));
      chk("t1_idle_data", 32'(data), 32'(0));
    end

    // 2: single data event, 2-cycle latency
    @(negedge clk);
    rx_data_valid = 1'b1;
    rx_data_addr  = 14'h0123;
    @(negedge clk);
    rx_data_valid = 1'b0;
    chk("t2_push_edge_vd", 32'(vd), 32'(0));
    @(negedge clk);
    chk("t2_vd", 32'(vd), 32'(1));
    chk("t2_vi", 32'(vi), 32'(0));
    chk("t2_data", 32'(data), 32'(14'h0123));
    @(negedge clk);
    chk("t2_vd_off", 32'(vd), 32'(0));

    // 3: simultaneous strobes, DATA wins the first tie
    @(negedge clk);
    rx_irq_valid  = 1'b1;
    rx_irq_addr   = 14'h0AAA;
    rx_data_valid = 1'b1;
    rx_data_addr  = 14'h1555;
    @(negedge clk);
    rx_irq_valid  = 1'b0;
    rx_data_valid = 1'b0;
    @(negedge clk);
    chk("t3_first_vd", 32'({vi, vd}), 32'(2'b01));
    chk("t3_first_data", 32'(data), 32'(14'h1555));
    @(negedge clk);
    chk("t3_second_vi", 32'({vi, vd}), 32'(2'b10));
    chk("t3_second_data", 32'(data), 32'(14'h0AAA));
    @(negedge clk);
    chk("t3_quiet", 32'({vi, vd}), 32'(0));

    // 4: six back-to-back irq events, in order, one per cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("t4_vi", 32'({vi, vd}), 32'(2'b10));
        chk("t4_data", 32'(data), 32'(16 + i - 2));
      end
      rx_irq_valid = (i < 6);
      rx_irq_addr  = 14'(16 + i);
    end
    chk("t4_no_ovf", 32'({ovf_irq, ovf_data}), 32'(0));
    idle(2);

    // 5: irq every cycle against data every other cycle -> one irq drop
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_irq_valid  = 1'b1;
      rx_irq_addr   = 14'(256 + i);
      rx_data_valid = (i % 2 == 0);
      rx_data_addr  = 14'(512 + i);
    end
    @(negedge clk);
    rx_irq_valid  = 1'b0;
    rx_data_valid = 1'b0;
    chk("t5_ovf_irq_set", 32'(ovf_irq), 32'(1));
    chk("t5_ovf_data_clear", 32'(ovf_data), 32'(0));
    idle(6);
    chk("t5_ovf_irq_sticky", 32'(ovf_irq), 32'(1));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t5_ovf_irq_cleared", 32'(ovf_irq), 32'(0));
    chk("t5_ovf_data_after_clr", 32'(ovf_data), 32'(0));
    idle(2);

    // 6: sustained contention, then asynchronous reset mid-stream
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_irq_valid  = 1'b1;
      rx_irq_addr   = 14'(768 + i);
      rx_data_valid = 1'b1;
      rx_data_addr  = 14'(1024 + i);
    end
    @(negedge clk);
    rx_irq_valid  = 1'b0;
    rx_data_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t6_async_valids", 32'({vi, vd}), 32'(0));
    chk("t6_async_data", 32'(data), 32'(0));
    chk("t6_async_ovf", 32'({ovf_irq, ovf_data}), 32'(0));
    idle(3);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t6_no_stale", 32'({vi, vd}), 32'(0));
    end

    @(negedge clk);
    chk("exp_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
